// File: rtl/booth_digit_if.sv
// rtl/booth_digit_if.sv - digit-in / word-out handshake bundle for the Booth digit decoder
interface booth_digit_if #(
    parameter int WIDTH = 16
);
    localparam int NUM_DIGITS = WIDTH / 2;
    localparam int CW         = $clog2(NUM_DIGITS) + 1;

    logic             digit_valid;
    logic             digit_ready;
    logic [2:0]       digit_code;
    logic             digit_last;
    logic             value_valid;
    logic             value_ready;
    logic [WIDTH-1:0] value;
    logic             err_continuity;
    logic             err_framing;
    logic [CW-1:0]    digit_count;

    modport master (
        output digit_valid, digit_code, digit_last, value_ready,
        input  digit_ready, value_valid, value, err_continuity, err_framing, digit_count
    );

    modport slave (
        input  digit_valid, digit_code, digit_last, value_ready,
        output digit_ready, value_valid, value, err_continuity, err_framing, digit_count
    );
endinterface

// File: rtl/booth_digit_decoder.sv
// rtl/booth_digit_decoder.sv - rebuilds a two's-complement word from radix-4 Booth triplets, LSD first
module booth_digit_decoder #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    booth_digit_if.slave bus
);
    localparam int NUM_DIGITS = WIDTH / 2;
    localparam int CW         = $clog2(NUM_DIGITS) + 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    idx;
    logic             prev_b2;

    logic             digit_ready_r;
    logic             value_valid_r;
    logic [WIDTH-1:0] value_r;
    logic             err_continuity_r;
    logic             err_framing_r;
    logic [CW-1:0]    digit_count_r;

    logic [2:0]       d;
    logic [WIDTH+1:0] d_ext;
    logic [WIDTH+1:0] acc_next;
    logic             transfer;
    logic             at_last;
    logic             mismatch;

    // Two's-complement arithmetic mod 2^(WIDTH+2) matches the signed accumulation.
    always_comb begin
        d        = 3'(bus.digit_code[1]) + 3'(bus.digit_code[0])
                 - (bus.digit_code[2] ? 3'd2 : 3'd0);
        d_ext    = {{(WIDTH-1){d[2]}}, d};
        acc_next = acc + (d_ext << {idx, 1'b0});
        transfer = bus.digit_valid && digit_ready_r;
        at_last  = (idx == CW'(NUM_DIGITS - 1));
        mismatch = (bus.digit_code[0] != prev_b2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= COLLECT;
            acc              <= '0;
            idx              <= '0;
            prev_b2          <= 1'b0;
            digit_ready_r    <= 1'b1;
            value_valid_r    <= 1'b0;
            value_r          <= '0;
            err_continuity_r <= 1'b0;
            err_framing_r    <= 1'b0;
            digit_count_r    <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (transfer) begin
                        acc           <= acc_next;
                        idx           <= idx + 1'b1;
                        prev_b2       <= bus.digit_code[2];
                        digit_count_r <= digit_count_r + 1'b1;
                        if (mismatch)
                            err_continuity_r <= 1'b1;
                        // Either a full word or an early last closes the word.
                        if (at_last || bus.digit_last) begin
                            state         <= HOLD;
                            digit_ready_r <= 1'b0;
                            value_valid_r <= 1'b1;
                            value_r       <= acc_next[WIDTH-1:0];
                            err_framing_r <= (bus.digit_last != at_last);
                        end
                    end
                end
                HOLD: begin
                    if (bus.value_ready) begin
                        state            <= COLLECT;
                        acc              <= '0;
                        idx              <= '0;
                        prev_b2          <= 1'b0;
                        digit_ready_r    <= 1'b1;
                        value_valid_r    <= 1'b0;
                        err_continuity_r <= 1'b0;
                        err_framing_r    <= 1'b0;
                        digit_count_r    <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.digit_ready    = digit_ready_r;
    assign bus.value_valid    = value_valid_r;
    assign bus.value          = value_r;
    assign bus.err_continuity = err_continuity_r;
    assign bus.err_framing    = err_framing_r;
    assign bus.digit_count    = digit_count_r;
endmodule

// File: tb/tb_booth_digit_decoder.sv
// tb/tb_booth_digit_decoder.sv - directed self-checking bench for booth_digit_decoder
module tb_booth_digit_decoder;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    booth_digit_if #(.WIDTH(16)) bus ();

    booth_digit_decoder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] trip(input logic [15:0] m, input int i);
        logic [16:0] e;
        e = {m, 1'b0};
        return e[2*i +: 3];
    endfunction

    task automatic send_digit(input logic [2:0] c, input logic last);
        int n;
        n = 0;
        bus.digit_valid = 1'b1;
        bus.digit_code  = c;
        bus.digit_last  = last;
        while (!bus.digit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("digit_ready_timeout", 32'(bus.digit_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        bus.digit_code  = 3'bxxx;
    endtask

    task automatic send_word(input logic [15:0] m, input int n, input int last_at, input int flip_at);
        for (int i = 0; i < n; i++) begin
            logic [2:0] c;
            c = trip(m, i);
            if (i == flip_at) c[0] = ~c[0];
            send_digit(c, i == last_at);
        end
    endtask

    task automatic take_value(input string tag, input logic [15:0] v, input logic ec,
                              input logic ef, input int cnt);
        int n;
        n = 0;
        while (!bus.value_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".value_valid"}, 32'(bus.value_valid), 32'd1);
        chk({tag, ".value"}, 32'(bus.value), 32'(v));
        chk({tag, ".err_continuity"}, 32'(bus.err_continuity), 32'(ec));
        chk({tag, ".err_framing"}, 32'(bus.err_framing), 32'(ef));
        chk({tag, ".digit_count"}, 32'(bus.digit_count), 32'(cnt));
        bus.value_ready = 1'b1;
        @(negedge clk);
        bus.value_ready = 1'b0;
        chk({tag, ".post_ready"}, 32'(bus.digit_ready), 32'd1);
        chk({tag, ".post_valid"}, 32'(bus.value_valid), 32'd0);
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst_n           = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit_code  = 3'b000;
        bus.digit_last  = 1'b0;
        bus.value_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.digit_ready", 32'(bus.digit_ready), 32'd1);
        chk("rst.value_valid", 32'(bus.value_valid), 32'd0);
        chk("rst.value", 32'(bus.value), 32'd0);
        chk("rst.errs", 32'({bus.err_continuity, bus.err_framing}), 32'd0);
        chk("rst.digit_count", 32'(bus.digit_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero word; value_valid must appear right after the 8th transfer.
        send_word(16'h0000, 7, -1, -1);
        chk("zero.valid_before_last", 32'(bus.value_valid), 32'd0);
        chk("zero.count7", 32'(bus.digit_count), 32'd7);
        send_digit(3'b000, 1'b1);
        chk("zero.valid_after_last", 32'(bus.value_valid), 32'd1);
        take_value("zero", 16'h0000, 1'b0, 1'b0, 8);

        send_word(16'hFFFF, 8, 7, -1);
        take_value("ffff", 16'hFFFF, 1'b0, 1'b0, 8);
        send_word(16'h7FFF, 8, 7, -1);
        take_value("7fff", 16'h7FFF, 1'b0, 1'b0, 8);
        send_word(16'h8000, 8, 7, -1);
        take_value("8000", 16'h8000, 1'b0, 1'b0, 8);

        // Backpressure: hold value_ready low, offer a digit during HOLD.
        send_word(16'h1234, 8, 7, -1);
        repeat (5) begin
            chk("hold.value", 32'(bus.value), 32'h1234);
            chk("hold.digit_ready", 32'(bus.digit_ready), 32'd0);
            @(negedge clk);
        end
        bus.digit_valid = 1'b1;
        bus.digit_code  = trip(16'h5A5A, 0);
        bus.digit_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold.count_unchanged", 32'(bus.digit_count), 32'd8);
        chk("hold.value_stable", 32'(bus.value), 32'h1234);
        chk("hold.valid_stable", 32'(bus.value_valid), 32'd1);
        bus.value_ready = 1'b1;
        @(negedge clk);
        bus.value_ready = 1'b0;
        chk("hold.released_count", 32'(bus.digit_count), 32'd0);
        chk("hold.released_valid", 32'(bus.value_valid), 32'd0);
        send_word(16'h5A5A, 8, 7, -1);
        take_value("after_hold", 16'h5A5A, 1'b0, 1'b0, 8);

        // 0x00A5 with digit 1 code[0] flipped: 010 -> 011 adds +4 -> 0x00A9.
        send_word(16'h00A5, 8, 7, 1);
        take_value("continuity", 16'h00A9, 1'b1, 1'b0, 8);

        // Early last at idx 3: digits 000,010,110,001 sum to 0x0034.
        send_word(16'h1234, 4, 3, -1);
        chk("early.valid", 32'(bus.value_valid), 32'd1);
        take_value("early_last", 16'h0034, 1'b0, 1'b1, 4);

        send_word(16'h00A5, 8, -1, -1);
        take_value("missing_last", 16'h00A5, 1'b0, 1'b1, 8);

        // Reset while holding a word: outputs clear without a clock edge.
        send_word(16'h1234, 8, 7, -1);
        chk("rst_hold.valid_before", 32'(bus.value_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold.valid", 32'(bus.value_valid), 32'd0);
        chk("rst_hold.value", 32'(bus.value), 32'd0);
        chk("rst_hold.digit_ready", 32'(bus.digit_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-word, then a clean word.
        send_word(16'hBEEF, 5, -1, -1);
        chk("rst_mid.count_before", 32'(bus.digit_count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.count", 32'(bus.digit_count), 32'd0);
        chk("rst_mid.errs", 32'({bus.err_continuity, bus.err_framing}), 32'd0);
        chk("rst_mid.value_valid", 32'(bus.value_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(16'hBEEF, 8, 7, -1);
        take_value("beef", 16'hBEEF, 1'b0, 1'b0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/booth_digit_decoder.md
Name: booth_digit_decoder

Overview:
Sequential radix-4 Booth digit decoder. It accepts a stream of Booth recoding triplets, least-significant digit first, over a valid/ready handshake. It reconstructs the original two's-complement multiplier word and presents it on a valid/ready output with per-word error flags. It is the inverse of the Booth encoder stage and is used as an in-datapath self-check and by the bench to close the loop on recoded multiplier streams.

Parameters:
- WIDTH, 16, multiplier width in bits. Must be even and >= 4.
- NUM_DIGITS (localparam), WIDTH/2, number of Booth digits per word.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- digit_valid  in  1  digit_code is valid this cycle.
- digit_ready  out  1  decoder can accept a digit.
- digit_code  in  3  Booth triplet {m[2i+1], m[2i], m[2i-1]}, with m[-1] = 0.
- digit_last  in  1  sender marks this as the final digit of the word.
- value_valid  out  1  reconstructed word available.
- value_ready  in  1  consumer accepts value.
- value  out  WIDTH  reconstructed two's-complement multiplier.
- err_continuity  out  1  overlap-bit mismatch seen in this word.
- err_framing  out  1  digit_last disagreed with the digit count.
- digit_count  out  $clog2(NUM_DIGITS)+1  digits accepted in the current or held word.

Behaviour:
- Reset (async assert, sync deassert): state COLLECT. Outputs go to digit_ready=1 and value_valid=0. value, err_continuity, err_framing and digit_count all go to 0. Internal acc, idx and prev_b2 are cleared.
- Digit transfer occurs when digit_valid && digit_ready.
- Digit value: d = -2*code[2] + code[1] + code[0], so d is in {-2..+2}. 000 and 111 decode to 0.
- Accumulator: signed, WIDTH+2 bits. Each transfer performs acc <= acc + (sign-extended d << 2*idx).
- Output value = acc[WIDTH-1:0], i.e. modulo 2^WIDTH.
- Continuity check: code[0] must equal prev_b2. For idx=0 it must equal 0. A mismatch sets err_continuity (sticky for the word) and the digit is still accumulated.
- FSM COLLECT:
  - digit_ready=1 and value_valid=0.
  - On a transfer, idx increments.
  - The word ends when idx==NUM_DIGITS-1 or digit_last=1, whichever comes first. The next state is then HOLD.
  - err_framing is set if digit_last != (idx==NUM_DIGITS-1). This covers both an early last and a missing last. An early last ends the word with a partial value.
- FSM HOLD:
  - digit_ready=0 and value_valid=1.
  - value, err flags and digit_count are stable while value_ready=0.
  - On value_ready=1: clear acc, idx, prev_b2 and the flags, then return to COLLECT the next cycle.
- Latency: value_valid rises the cycle after the final digit transfer. A full word takes NUM_DIGITS+1 cycles minimum from the first digit to value_valid.
- Throughput: one bubble cycle between words. digit_ready is low during HOLD and there is no skid buffer.
- digit_valid during HOLD is ignored; the sender must hold the digit until digit_ready.
- value_ready while in COLLECT is ignored.
- Reset mid-word or during HOLD discards the partial or held word immediately. value_valid drops asynchronously.
- digit_code is don't-care when digit_valid=0. X on digit_code with valid=0 must not propagate into the state.

Test Plan:
- WIDTH=16, eight digits 000 with digit_last on the 8th -> value=0x0000, both errs 0, digit_count=8, value_valid exactly 1 cycle after the 8th transfer.
- Multiplier 0xFFFF, digits 110 then 7×111 -> value=0xFFFF. Multiplier 0x7FFF, digits 110, 6×111, 011 -> value=0x7FFF. Multiplier 0x8000, digits 7×000 then 100 -> value=0x8000. Errors are 0 in all three cases.
- Encoded 0x1234 stream with value_ready held low for 5 cycles -> value=0x1234 stable; digit_ready=0 during HOLD; a digit offered in HOLD is not consumed. After value_ready, the next word decodes correctly.
- Digit 1 code[0] flipped from the correct stream for 0x00A5 -> err_continuity=1. value equals the arithmetic sum of the codes as sent.
- digit_last asserted on digit 3 (idx=3) -> HOLD after 4 digits, err_framing=1, digit_count=4. A separate word with no last on the 8th digit -> err_framing=1.
- rst_n pulsed low after 5 digits -> all outputs return to reset values. The next clean 8-digit word for 0xBEEF -> value=0xBEEF with no errors.
